// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, round-count helper, inverse S-box,
// GF(2^8) multiply helpers and the decrypt FSM state type.
package aes_pkg;

  localparam int Nb = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } aes_state_e;

  function automatic int aes_nr(input int nk);
    return nk + 6;
  endfunction

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplier is at most 4 bits wide: only 9, 11, 13 and 14 are needed.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// Start/done handshake and data buses of the AES decrypt core.
// The abort signal exists only when AES_DEC_ABORT_EN is defined.
interface aes_decrypt_core_if;
  logic         start;
  logic [127:0] ct;
  logic [127:0] pt;
  logic         done;
  logic         busy;
`ifdef AES_DEC_ABORT_EN
  logic         abort;
  modport master (output start, ct, abort, input pt, done, busy);
  modport slave  (input start, ct, abort, output pt, done, busy);
`else
  modport master (output start, ct, input pt, done, busy);
  modport slave  (input start, ct, output pt, done, busy);
`endif
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey,
// followed by InvMixColumns unless last_i is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  // Byte b sits at row b%4, column b/4; byte 0 is in the MSBs.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = INV_SBOX[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
      o[119-32*c -: 8] = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
      o[111-32*c -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
      o[103-32*c -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
    end
    return o;
  endfunction

  logic [127:0] keyed;

  assign keyed   = inv_shift_sub(state_i) ^ rk_i;
  assign state_o = last_i ? keyed : inv_mix(keyed);

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES inverse cipher, one round per clock, start/done handshake.
// Optional abort input is enabled by defining AES_DEC_ABORT_EN.
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int Nk = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [128*(aes_nr(Nk)+1)-1:0] w,
  aes_decrypt_core_if.slave             bus
);

  localparam int         Nr        = aes_nr(Nk);
  localparam int         BW        = 32 * Nb;
  localparam logic [3:0] RND_FIRST = 4'(Nr - 1);

  aes_state_e    fsm_q, fsm_d;
  logic [BW-1:0] state_q, state_d;
  logic [BW-1:0] pt_q, pt_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          done_q, done_d;
  logic [BW-1:0] rk_cur, rk_init, round_out;
  logic          abort_w;

  // Round key r is stored with round 0 in the MSBs, so rk[Nr] is the bottom word.
  assign rk_cur  = w[128*(Nr+1)-1-128*int'(rnd_q) -: 128];
  assign rk_init = w[127:0];

`ifdef AES_DEC_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  aes_inv_round u_round (
    .state_i (state_q),
    .rk_i    (rk_cur),
    .last_i  (rnd_q == 4'd0),
    .state_o (round_out)
  );

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        // abort in IDLE suppresses a simultaneous start
        if (bus.start && !abort_w) begin
          state_d = bus.ct ^ rk_init;
          rnd_d   = RND_FIRST;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (abort_w) begin
          fsm_d = IDLE;
        end else if (rnd_q == 4'd0) begin
          pt_d   = round_out;
          done_d = 1'b1;
          fsm_d  = IDLE;
        end else begin
          state_d = round_out;
          rnd_d   = rnd_q - 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
    end
  end

  assign bus.pt   = pt_q;
  assign bus.done = done_q;
  assign bus.busy = (fsm_q == ROUND);

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core at Nk = 4, 6, 8; expected plaintexts come
// from a forward-cipher model and key expansion written from the AES definition.
module tb_aes_decrypt_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic         start_s [3];
  logic [127:0] ct_s    [3];
  logic [127:0] pt_s    [3];
  logic         done_s  [3];
  logic         busy_s  [3];
  logic [1919:0] wf     [3];
  logic [7:0]   sbox_m  [256];
`ifdef AES_DEC_ABORT_EN
  logic         abort_s [3];
`endif

  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                          128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                          128'h8ea2b7ca516745bfeafc49904b496089};

  always #5 clk = ~clk;

  aes_decrypt_core_if if4 ();
  aes_decrypt_core_if if6 ();
  aes_decrypt_core_if if8 ();

  assign if4.start = start_s[0];
  assign if6.start = start_s[1];
  assign if8.start = start_s[2];
  assign if4.ct    = ct_s[0];
  assign if6.ct    = ct_s[1];
  assign if8.ct    = ct_s[2];
  assign pt_s[0]   = if4.pt;
  assign pt_s[1]   = if6.pt;
  assign pt_s[2]   = if8.pt;
  assign done_s[0] = if4.done;
  assign done_s[1] = if6.done;
  assign done_s[2] = if8.done;
  assign busy_s[0] = if4.busy;
  assign busy_s[1] = if6.busy;
  assign busy_s[2] = if8.busy;
`ifdef AES_DEC_ABORT_EN
  assign if4.abort = abort_s[0];
  assign if6.abort = abort_s[1];
  assign if8.abort = abort_s[2];
`endif

  aes_decrypt_core #(.Nk(4)) dut4 (.clk(clk), .rst(rst), .w(wf[0][1407:0]), .bus(if4));
  aes_decrypt_core #(.Nk(6)) dut6 (.clk(clk), .rst(rst), .w(wf[1][1663:0]), .bus(if6));
  aes_decrypt_core #(.Nk(8)) dut8 (.clk(clk), .rst(rst), .w(wf[2][1919:0]), .bus(if8));

  // ---------------- reference model ----------------
  function automatic int nr_of(input int d);
    return 10 + 2 * d;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Forward S-box: multiplicative inverse followed by the affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  // Returns the schedule packed with round 0 at bit 128*(Nr+1)-1.
  function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] v;
    int            nr;
    nr = nk + 6;
    rc = 8'h01;
    v  = '0;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        wd[i] = key[255-32*i -: 32];
      end else begin
        t = wd[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        wd[i] = wd[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++)
      v[128*(nr+1)-1-128*r -: 128] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    return v;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [1919:0] v, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] o;
    rk = v[128*(nr+1)-1 -: 128];
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          t[4*c+rw] = sbox_m[s[4*((c+rw)%4)+rw]];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      rk = v[128*(nr+1)-1-128*r -: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Counts rising edges until done is seen; n = -1 if it never appears within limit.
  task automatic wait_done(input int d, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_s[d] === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_block(input int d, input logic [127:0] ct, input logic [127:0] exp_pt, input string name);
    int n;
    @(negedge clk);
    checks++;
    if (busy_s[d] !== 1'b0) begin errors++; $display("FAIL %s idle_busy: got %b expected 0", name, busy_s[d]); end
    start_s[d] = 1'b1;
    ct_s[d]    = ct;
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
    ct_s[d]    = rand128();
    @(negedge clk);
    checks++;
    if (busy_s[d] !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept: got %b expected 1", name, busy_s[d]); end
    wait_done(d, nr_of(d) + 4, n);
    checks++;
    if (n != nr_of(d)) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, n, nr_of(d)); end
    checks++;
    if (pt_s[d] !== exp_pt) begin errors++; $display("FAIL %s pt: got %h expected %h", name, pt_s[d], exp_pt); end
    checks++;
    if (busy_s[d] !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b expected 0", name, busy_s[d]); end
    @(negedge clk);
    checks++;
    if (done_s[d] !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width: got %b expected 0", name, done_s[d]); end
    checks++;
    if (pt_s[d] !== exp_pt) begin errors++; $display("FAIL %s pt_hold: got %h expected %h", name, pt_s[d], exp_pt); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      ct_s[d]    = '0;
`ifdef AES_DEC_ABORT_EN
      abort_s[d] = 1'b0;
`endif
    end
    #1 rst = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pt_s[d] !== 128'h0) begin errors++; $display("FAIL reset_pt[%0d]: got %h expected 0", d, pt_s[d]); end
      checks++;
      if (done_s[d] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", d, done_s[d]); end
      checks++;
      if (busy_s[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy_s[d]); end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_kat();
    for (int d = 0; d < 3; d++)
      run_block(d, KAT_CT[d], KAT_PT, $sformatf("kat_nk%0d", 4 + 2 * d));
  endtask

  task automatic test_random();
    int           d;
    logic [127:0] p;
    for (int i = 0; i < 12; i++) begin
      d     = i % 3;
      wf[d] = expand(4 + 2 * d, {rand128(), rand128()});
      p     = rand128();
      run_block(d, encrypt(p, wf[d], nr_of(d)), p, $sformatf("rand%0d_nk%0d", i, 4 + 2 * d));
    end
    for (int k = 0; k < 3; k++) wf[k] = expand(4 + 2 * k, KAT_KEY);
  endtask

  task automatic test_start_ignored();
    int n;
    @(negedge clk);
    start_s[2] = 1'b1;
    ct_s[2]    = KAT_CT[2];
    @(posedge clk);
    #1 start_s[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start_s[2] = 1'b1;
    ct_s[2]    = rand128();
    @(posedge clk);
    #1 start_s[2] = 1'b0;
    wait_done(2, 15, n);
    checks++;
    if (n != 9) begin errors++; $display("FAIL ignored_start_latency: got %0d expected 9 edges after k+5", n); end
    checks++;
    if (pt_s[2] !== KAT_PT) begin errors++; $display("FAIL ignored_start_pt: got %h expected %h", pt_s[2], KAT_PT); end
    wait_done(2, 20, n);
    checks++;
    if (n != -1) begin errors++; $display("FAIL ignored_start_queued: got done after %0d edges expected none", n); end
  endtask

  task automatic test_back_to_back();
    int           n;
    logic [127:0] p1, p2;
    p1 = rand128();
    p2 = rand128();
    @(negedge clk);
    start_s[2] = 1'b1;
    ct_s[2]    = encrypt(p1, wf[2], 14);
    @(posedge clk);
    #1 ct_s[2] = encrypt(p2, wf[2], 14);
    wait_done(2, 20, n);
    checks++;
    if (n != 14) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 14", n); end
    checks++;
    if (pt_s[2] !== p1) begin errors++; $display("FAIL b2b_first_pt: got %h expected %h", pt_s[2], p1); end
    @(posedge clk);
    #1 start_s[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_s[2] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy got %b expected 1", busy_s[2]); end
    wait_done(2, 20, n);
    checks++;
    if (n != 14) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 14 (done after k+29)", n); end
    checks++;
    if (pt_s[2] !== p2) begin errors++; $display("FAIL b2b_second_pt: got %h expected %h", pt_s[2], p2); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    start_s[2] = 1'b1;
    ct_s[2]    = KAT_CT[2];
    @(posedge clk);
    #1 start_s[2] = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (pt_s[2] !== 128'h0) begin errors++; $display("FAIL midreset_pt: got %h expected 0", pt_s[2]); end
    checks++;
    if (busy_s[2] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy_s[2]); end
    checks++;
    if (done_s[2] !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done_s[2]); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_done(2, 20, n);
    checks++;
    if (n != -1) begin errors++; $display("FAIL midreset_stray_done: got done after %0d edges expected none", n); end
    run_block(2, KAT_CT[2], KAT_PT, "after_reset");
  endtask

`ifdef AES_DEC_ABORT_EN
  task automatic test_abort();
    int           n;
    logic [127:0] p, c;
    p = rand128();
    c = encrypt(p, wf[2], 14);
    // abort mid-run
    @(negedge clk);
    start_s[2] = 1'b1;
    ct_s[2]    = c;
    @(posedge clk);
    #1 start_s[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1 abort_s[2] = 1'b1;
    @(posedge clk);
    #1 abort_s[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_s[2] !== 1'b0) begin errors++; $display("FAIL abort_mid_busy: got %b expected 0", busy_s[2]); end
    wait_done(2, 20, n);
    checks++;
    if (n != -1) begin errors++; $display("FAIL abort_mid_done: got done after %0d edges expected none", n); end
    checks++;
    if (pt_s[2] !== KAT_PT) begin errors++; $display("FAIL abort_mid_pt: got %h expected %h", pt_s[2], KAT_PT); end
    // abort coinciding with the final-round edge
    @(negedge clk);
    start_s[2] = 1'b1;
    @(posedge clk);
    #1 start_s[2] = 1'b0;
    repeat (13) @(posedge clk);
    #1 abort_s[2] = 1'b1;
    @(posedge clk);
    #1 abort_s[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (done_s[2] !== 1'b0) begin errors++; $display("FAIL abort_final_done: got %b expected 0", done_s[2]); end
    checks++;
    if (busy_s[2] !== 1'b0) begin errors++; $display("FAIL abort_final_busy: got %b expected 0", busy_s[2]); end
    checks++;
    if (pt_s[2] !== KAT_PT) begin errors++; $display("FAIL abort_final_pt: got %h expected %h", pt_s[2], KAT_PT); end
    // abort in IDLE blocks start
    @(negedge clk);
    start_s[2] = 1'b1;
    abort_s[2] = 1'b1;
    @(posedge clk);
    #1;
    start_s[2] = 1'b0;
    abort_s[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_s[2] !== 1'b0) begin errors++; $display("FAIL abort_idle_accept: busy got %b expected 0", busy_s[2]); end
    wait_done(2, 20, n);
    checks++;
    if (n != -1) begin errors++; $display("FAIL abort_idle_done: got done after %0d edges expected none", n); end
    run_block(2, c, p, "after_abort");
  endtask
`endif

  initial begin
    build_sbox();
    for (int k = 0; k < 3; k++) wf[k] = expand(4 + 2 * k, KAT_KEY);
    test_reset();
    test_kat();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_DEC_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
